parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial frame receiver that sits directly upstream of the byte-parity tree. It recovers 8-bit data frames from a single asynchronous serial line: 1 start bit, 8 data bits LSB first, 1 parity bit, 1 stop bit. It presents each recovered byte on a parallel bus in the same bit order the parity tree consumes. It also checks the received parity bit, flags framing faults and keeps a saturating error count.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit. Must be even and ≥ 4.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line. Idle is 1. Asynchronous to clk.
- odd_parity  in  1  0 selects even parity, 1 selects odd. Captured at start-bit confirmation.
- err_clr  in  1  synchronous clear of err_count.
- data_out  out  8  last received byte. data_out[0] is the first data bit received.
- data_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  parity fault on the last frame.
- frame_err  out  1  stop bit of the last frame sampled as 0.
- err_count  out  4  frames with any error. Saturates at 15.
- busy  out  1  high while a frame is in progress.

## Operation
- **rx synchronisation:** rx passes through a 2-flop synchroniser. Both flops reset to 1. All logic below uses the synchronised value rxs.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK.
- **IDLE:**
  - rxs=0 moves to START and loads the bit counter with CLKS_PER_BIT/2−1.
  - busy=0 only in IDLE.
- **START, at counter expiry (mid start bit):**
  - rxs=1 means false start: return to IDLE. No flags change.
  - rxs=0: latch odd_parity, reload the counter with CLKS_PER_BIT−1, go to DATA.
- **DATA:**
  - Sample rxs at each counter expiry into shift register bit index 0..7.
  - After the 8th sample, go to PARITY.
- **PARITY:** sample the parity bit p, then go to STOP.
- **STOP, at sample time:**
  - data_out ← shift register.
  - parity_err ← (^data ^ p) != odd_parity_latched.
  - frame_err ← ~rxs.
  - data_valid=1 for exactly this cycle.
  - If rxs=1, go to IDLE. If rxs=0, go to BREAK.
- **BREAK:** wait for rxs=1, then go to IDLE. No start is detected while in BREAK.
- **Output hold:** data_out, parity_err and frame_err hold until the next STOP sample. They do not change on a false start.
- **err_count:**
  - +1 on a data_valid cycle when parity_err|frame_err is set for that frame. One increment per frame, even if both errors are set.
  - Holds at 15.
  - err_clr forces it to 0. err_clr wins over a simultaneous increment.
- **odd_parity changes:** changing odd_parity mid-frame has no effect on the current frame.
- **Reset:**
  - Outputs reset as follows: data_out=0x00, data_valid=0, parity_err=0, frame_err=0, err_count=0, busy=0, FSM=IDLE.
  - Assertion mid-frame aborts the frame immediately. No data_valid is produced for it.

## Timing
- Let cycle 0 be the first clk edge at which rx is registered low. rxs goes low at cycle 2; START is entered at cycle 2.
- Start-bit confirmation at cycle 2 + CLKS_PER_BIT/2.
- Data bit k (k=0..7) is sampled at cycle 2 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Parity bit sampled 9·CLKS_PER_BIT after confirmation.
- Stop bit sampled 10·CLKS_PER_BIT after confirmation. data_valid is high in that same cycle.
- Total latency from the start edge to data_valid: 2 + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT cycles. This is 44 cycles at the default.
- IDLE is re-entered the cycle after data_valid. A new start may be detected from then on, so back-to-back frames with a 1-bit stop need no gap.
- err_count updates on the cycle after data_valid. Flags update with data_valid.

## Test plan
- **Good frame:** CLKS_PER_BIT=4, even mode, send 0xA5 with p=0 and stop=1. Expect data_valid at cycle 44 with data_out=0xA5, parity_err=0, frame_err=0, err_count=0.
- **Parity error:** even mode, send 0x01 with p=0. Expect parity_err=1, frame_err=0, err_count=1. Then odd mode, send 0x01 with p=0. Expect parity_err=0 and err_count still 1.
- **Framing error / break:**
  - Send 0x3C, correct parity, stop=0, then hold rx=0 for 40 cycles. Expect frame_err=1, err_count+1 and busy=1 throughout.
  - No second data_valid until rx returns to 1 and a new start occurs.
- **False start:** drive rx low for 1 cycle, then high. Expect busy to rise and fall within 6 cycles, no data_valid, and flags unchanged.
- **Back-to-back and reset:**
  - Two consecutive frames 0x00 and 0xFF with no idle gap: two data_valid pulses exactly 44 cycles apart, correct data.
  - Assert rst during data bit 4 of a third frame: all outputs go to reset values immediately, and no data_valid is produced.
- **Saturation and clear:** send 17 frames with parity errors and expect err_count=15. Assert err_clr in the same cycle as an increment and expect err_count=0.

Source files
------------

// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
//
// Serial frame receiver feeding the byte-parity tree. Recovers frames of
// 1 start bit, 8 data bits (LSB first), 1 parity bit and 1 stop bit from an
// asynchronous serial line. It checks parity, flags framing faults and keeps a
// saturating count of bad frames.
//
// Parameters
//   CLKS_PER_BIT   clock cycles per serial bit (even, >= 4)
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   i_rx           serial line, idle high, asynchronous to clk
//   i_odd_parity   0 = even parity, 1 = odd parity (captured at start confirm)
//   i_err_clr      synchronous clear of o_err_count (wins over an increment)
//   o_data_out     last received byte, bit 0 = first data bit on the line
//   o_data_valid   one-cycle pulse at the stop-bit sample of each frame
//   o_parity_err   parity fault on the last frame
//   o_frame_err    stop bit of the last frame sampled low
//   o_err_count    frames with any error, saturates at 15
//   o_busy         high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module parity_frame_rx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic       i_odd_parity,
    input  logic       i_err_clr,
    output logic [7:0] o_data_out,
    output logic       o_data_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic [3:0] o_err_count,
    output logic       o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic          r_rx_meta;
    logic          r_rxs;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_par_bit;
    logic          r_odd_lat;
    logic [7:0]    r_data_out;
    logic          r_data_valid;
    logic          r_parity_err;
    logic          r_frame_err;
    logic [3:0]    r_err_count;

    logic          w_expire;
    logic          w_parity_err;

    // Counter expiry marks the middle of the current bit.
    assign w_expire     = (r_cnt == '0);
    // Total ones across data and parity bit must match the latched mode.
    assign w_parity_err = ((^r_shift) ^ r_par_bit) != r_odd_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rxs        <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_par_bit    <= 1'b0;
            r_odd_lat    <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rxs        <= r_rx_meta;
            r_data_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_HALF;
                    end
                end

                S_START: begin
                    if (w_expire) begin
                        if (r_rxs) begin
                            // Glitch shorter than half a bit: ignore silently.
                            r_state <= S_IDLE;
                        end else begin
                            r_odd_lat <= i_odd_parity;
                            r_cnt     <= CNT_FULL;
                            r_bit_idx <= 3'd0;
                            r_state   <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_expire) begin
                        r_shift[r_bit_idx] <= r_rxs;
                        r_cnt              <= CNT_FULL;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_PARITY: begin
                    if (w_expire) begin
                        r_par_bit <= r_rxs;
                        r_cnt     <= CNT_FULL;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_expire) begin
                        r_data_out   <= r_shift;
                        r_parity_err <= w_parity_err;
                        r_frame_err  <= ~r_rxs;
                        r_data_valid <= 1'b1;
                        // A low stop bit is treated as a line break; the line
                        // must return high before another start is accepted.
                        r_state      <= r_rxs ? S_IDLE : S_BREAK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_BREAK: begin
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Error counter runs one cycle behind data_valid so it sees the flags
    // of the frame that just completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 4'd0;
        end else if (i_err_clr) begin
            r_err_count <= 4'd0;
        end else if (r_data_valid && (r_parity_err || r_frame_err)
                     && (r_err_count != 4'hF)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_err_count  = r_err_count;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_rx
//
// Directed testbench for parity_frame_rx at CLKS_PER_BIT = 4. Each scenario
// task drives the serial line and checks outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_parity_frame_rx;

    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       odd_parity;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic [3:0] err_count;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int start_cyc = 0;

    // Record of every data_valid pulse seen
    logic [7:0] q_data[$];
    logic       q_pe[$];
    logic       q_fe[$];
    int         q_cyc[$];

    parity_frame_rx #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx),
        .i_odd_parity (odd_parity),
        .i_err_clr    (err_clr),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .o_parity_err (parity_err),
        .o_frame_err  (frame_err),
        .o_err_count  (err_count),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            q_data.push_back(data_out);
            q_pe.push_back(parity_err);
            q_fe.push_back(frame_err);
            q_cyc.push_back(cyc);
            $display("frame: data=%02h parity_err=%0b frame_err=%0b cycle=%0d",
                     data_out, parity_err, frame_err, cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_data.delete();
        q_pe.delete();
        q_fe.delete();
        q_cyc.delete();
    endtask

    // Drive one full frame; odd_parity is toggled at data bit flip_bit (-1 = never).
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int flip_bit);
        rx = 1'b0;
        start_cyc = cyc + 1;
        repeat (C) tick();
        for (int k = 0; k < 8; k++) begin
            rx = d[k];
            if (k == flip_bit) odd_parity = ~odd_parity;
            repeat (C) tick();
        end
        rx = p;
        repeat (C) tick();
        rx = stop;
        repeat (C) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total_cnt++;
        if ({data_out, data_valid, parity_err, frame_err, err_count, busy} !== 16'h0000)
            $display("FAIL reset_in_reset: got %h expected 0000",
                     {data_out, data_valid, parity_err, frame_err, err_count, busy});
        else pass_cnt++;
        rst = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (busy !== 1'b0 || err_count !== 4'd0 || data_out !== 8'h00)
            $display("FAIL reset_release: busy=%b cnt=%0d data=%02h expected 0,0,00",
                     busy, err_count, data_out);
        else pass_cnt++;
    endtask

    task automatic test_good_frame();
        clear_log();
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        repeat (3) tick();
        total_cnt++;
        if (q_data.size() != 1) $display("FAIL good_count: got %0d expected 1", q_data.size());
        else pass_cnt++;
        total_cnt++;
        if (q_data.size() < 1 || q_cyc[0] - start_cyc != 44)
            $display("FAIL good_latency: got %0d expected 44",
                     (q_cyc.size() > 0) ? q_cyc[0] - start_cyc : -1);
        else pass_cnt++;
        total_cnt++;
        if (q_data.size() < 1 || q_data[0] !== 8'hA5 || q_pe[0] !== 1'b0 || q_fe[0] !== 1'b0)
            $display("FAIL good_data: got %02h/%b/%b expected a5/0/0",
                     (q_data.size() > 0) ? q_data[0] : 8'hxx,
                     (q_pe.size() > 0) ? q_pe[0] : 1'bx,
                     (q_fe.size() > 0) ? q_fe[0] : 1'bx);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 4'd0) $display("FAIL good_errcnt: got %0d expected 0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_parity_error();
        clear_log();
        odd_parity = 1'b0;
        send_frame(8'h01, 1'b0, 1'b1, -1);
        repeat (3) tick();
        total_cnt++;
        if (parity_err !== 1'b1 || frame_err !== 1'b0 || data_out !== 8'h01)
            $display("FAIL par_even: pe=%b fe=%b data=%02h expected 1,0,01",
                     parity_err, frame_err, data_out);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 4'd1) $display("FAIL par_even_cnt: got %0d expected 1", err_count);
        else pass_cnt++;

        odd_parity = 1'b1;
        send_frame(8'h01, 1'b0, 1'b1, -1);
        repeat (3) tick();
        total_cnt++;
        if (parity_err !== 1'b0 || err_count !== 4'd1)
            $display("FAIL par_odd: pe=%b cnt=%0d expected 0,1", parity_err, err_count);
        else pass_cnt++;

        // Mode flips to odd during the frame; even mode must still apply.
        odd_parity = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 3);
        repeat (3) tick();
        total_cnt++;
        if (parity_err !== 1'b0 || err_count !== 4'd1 || q_data.size() != 3)
            $display("FAIL par_midflip: pe=%b cnt=%0d frames=%0d expected 0,1,3",
                     parity_err, err_count, q_data.size());
        else pass_cnt++;
        odd_parity = 1'b0;
    endtask

    task automatic test_break();
        logic busy_low;
        clear_log();
        busy_low = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        repeat (40) begin
            tick();
            if (busy !== 1'b1) busy_low = 1'b1;
        end
        total_cnt++;
        if (busy_low !== 1'b0) $display("FAIL break_busy: got busy low expected high throughout");
        else pass_cnt++;
        total_cnt++;
        if (q_data.size() != 1 || frame_err !== 1'b1 || parity_err !== 1'b0 || data_out !== 8'h3C)
            $display("FAIL break_flags: frames=%0d fe=%b pe=%b data=%02h expected 1,1,0,3c",
                     q_data.size(), frame_err, parity_err, data_out);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 4'd2) $display("FAIL break_cnt: got %0d expected 2", err_count);
        else pass_cnt++;
        rx = 1'b1;
        repeat (4) tick();
        total_cnt++;
        if (busy !== 1'b0 || q_data.size() != 1)
            $display("FAIL break_exit: busy=%b frames=%0d expected 0,1", busy, q_data.size());
        else pass_cnt++;
    endtask

    task automatic test_false_start();
        int rose;
        int fell;
        clear_log();
        rose = -1;
        fell = -1;
        rx = 1'b0;
        tick();
        rx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy === 1'b1 && rose < 0) rose = i;
            if (busy === 1'b0 && rose >= 0 && fell < 0) fell = i;
        end
        total_cnt++;
        if (rose < 0 || fell <= rose || fell - rose > 6)
            $display("FAIL false_busy: rose=%0d fell=%0d expected short pulse", rose, fell);
        else pass_cnt++;
        total_cnt++;
        if (q_data.size() != 0 || data_out !== 8'h3C || frame_err !== 1'b1
            || parity_err !== 1'b0 || err_count !== 4'd2)
            $display("FAIL false_hold: frames=%0d data=%02h fe=%b pe=%b cnt=%0d expected 0,3c,1,0,2",
                     q_data.size(), data_out, frame_err, parity_err, err_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(8'h00, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        repeat (3) tick();
        total_cnt++;
        if (q_data.size() != 2) $display("FAIL b2b_count: got %0d expected 2", q_data.size());
        else pass_cnt++;
        total_cnt++;
        if (q_cyc.size() < 2 || q_cyc[1] - q_cyc[0] != 44)
            $display("FAIL b2b_spacing: got %0d expected 44",
                     (q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (q_data.size() < 2 || q_data[0] !== 8'h00 || q_data[1] !== 8'hFF
            || q_pe[1] !== 1'b0 || q_fe[1] !== 1'b0)
            $display("FAIL b2b_data: got %02h %02h expected 00 ff, no errors",
                     (q_data.size() > 0) ? q_data[0] : 8'hxx,
                     (q_data.size() > 1) ? q_data[1] : 8'hxx);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h5A;
        clear_log();
        rx = 1'b0;
        repeat (C) tick();
        for (int k = 0; k < 4; k++) begin
            rx = d[k];
            repeat (C) tick();
        end
        rx = d[4];
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({data_out, data_valid, parity_err, frame_err, err_count, busy} !== 16'h0000)
            $display("FAIL rst_mid_outputs: got %h expected 0000",
                     {data_out, data_valid, parity_err, frame_err, err_count, busy});
        else pass_cnt++;
        tick();
        rst = 1'b0;
        rx = 1'b1;
        repeat (60) tick();
        total_cnt++;
        if (q_data.size() != 0 || busy !== 1'b0)
            $display("FAIL rst_mid_novalid: frames=%0d busy=%b expected 0,0", q_data.size(), busy);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        odd_parity = 1'b0;
        for (int n = 0; n < 17; n++) send_frame(8'h01, 1'b0, 1'b1, -1);
        repeat (3) tick();
        total_cnt++;
        if (err_count !== 4'd15) $display("FAIL sat_count: got %0d expected 15", err_count);
        else pass_cnt++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total_cnt++;
        if (err_count !== 4'd0) $display("FAIL clr_count: got %0d expected 0", err_count);
        else pass_cnt++;
        send_frame(8'h01, 1'b0, 1'b1, -1);
        tick();
        total_cnt++;
        if (data_valid !== 1'b1 || parity_err !== 1'b1)
            $display("FAIL clr_align: dv=%b pe=%b expected 1,1", data_valid, parity_err);
        else pass_cnt++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (2) tick();
        total_cnt++;
        if (err_count !== 4'd0) $display("FAIL clr_priority: got %0d expected 0", err_count);
        else pass_cnt++;
    endtask

    initial begin
        rst        = 1'b1;
        rx         = 1'b1;
        odd_parity = 1'b0;
        err_clr    = 1'b0;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_break();
        test_false_start();
        test_back_to_back();
        test_reset_midframe();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
